sdram_rd_capture: RTL and testbench
===================================

// Module: sdram_rd_capture
// PURPOSE
//  Downstream of the SDRAM read sequencer. Watches the 4-bit command the sequencer drives to the SDRAM pins.
//  For each CMD_RD, captures the burst returned on DQ after the CAS latency.
//  Captured words are buffered in a synchronous FIFO and presented to the user side over a valid/ready stream.
//  Also flags overflow when the user side stalls while reads keep issuing.
// PARAMETERS
//  DATA_W      16  SDRAM DQ / output data width
//  CAS_LAT     3   CAS latency in clk cycles (legal 2..3); must match mode register
//  BURST_LEN   4   words per CMD_RD (power of 2, 1..8); must match mode register
//  FIFO_AW     4   FIFO address width; depth = 2**FIFO_AW (16)
// PORTS
//  clk         in   1        system clock, all logic on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  rd_cmd      in   4        {CS_N,RAS_N,CAS_N,WE_N} from read sequencer, pin-aligned
//  sdram_dq    in   DATA_W   SDRAM data bus (read direction)
//  dout        out  DATA_W   FIFO head word
//  dout_valid  out  1        dout holds a valid word
//  dout_ready  in   1        consumer accepts dout this cycle
//  fifo_level  out  FIFO_AW+1  words currently buffered (0..2**FIFO_AW)
//  ovf_err     out  1        sticky: a captured word was dropped on full FIFO
//  err_clr     in   1        synchronous clear of ovf_err
// BEHAVIOUR
//  - Reset: dout=0, dout_valid=0, fifo_level=0, ovf_err=0, delay line cleared, capture FSM in S_IDLE.
//    Async reset mid-burst discards all in-flight and buffered data.
//  - Read detect: rd_start = (rd_cmd==CMD_RD 4'b0101) in cycle T. Other commands (NOP, ACT, PRE, AREF) are ignored.
//  - Delay line: CAS_LAT-deep shift register of rd_start. Its output asserts in cycle T+CAS_LAT, when DQ word 0 is valid at the pins.
//  - DQ register: sdram_dq is registered every cycle (dq_q). A word valid in cycle C is written to the FIFO at the end of cycle C+1.
//    Fixed latency is CAS_LAT+2 from rd_cmd==CMD_RD to the first word visible on dout (FIFO was empty).
//  - Capture FSM:
//      S_IDLE  -> S_BURST on delay-line output; beat_cnt loaded 0.
//      S_BURST: each cycle capture one word and beat_cnt++.
//               On beat_cnt==BURST_LEN-1: if the delay-line output is asserted in the same cycle, reload beat_cnt=0 and stay (back-to-back bursts, no gap).
//               Otherwise return to S_IDLE.
//    A CMD_RD arriving while a previous burst is still in the delay line or capture is legal. Only terminating a burst early (read-interrupt) is unsupported.
//    Such a CMD_RD overlapping a non-final beat is ignored for capture start, and ovf_err is set.
//  - FIFO: first-word-fall-through; dout_valid = !empty; pop on dout_valid&&dout_ready.
//    Simultaneous push+pop at full is allowed: level is unchanged and no drop.
//    Push when full without a pop drops the word and sets ovf_err. ovf_err stays until err_clr or reset.
//    If err_clr and a new drop coincide, ovf_err remains 1.
//  - fifo_level: registered, updated the same edge as push/pop; pointers wrap modulo 2**FIFO_AW with extra MSB for full/empty.
//  - dout_ready while !dout_valid is a no-op.
// CONFIGURATION
//  RDCAP_WORD_CNT_EN defined:
//    adds output port word_cnt[31:0], the count of words written to the FIFO (drops excluded).
//    Wraps at 2**32, reset 0, cleared together with ovf_err by err_clr.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared header sdram_defs.vh: CMD_NOP/PRE/AREF/ACT/RD/WR encodings, and CAS_LAT/BURST_LEN defaults shared with the sequencers and init block.
//  One sub-module: rdcap_sync_fifo (DATA_W, FIFO_AW; FWFT, level output). The delay line, DQ register, capture FSM and error flag stay in the top.
// TESTING
//  1 Reset: hold rst_n=0 with DQ toggling and rd_cmd=0101 -> dout_valid=0, fifo_level=0, ovf_err=0 throughout.
//  2 Single read: CMD_RD at cycle 10, DQ drives 3,5,7,9 in cycles 13..16, dout_ready=1 -> dout_valid rises cycle 15 with 3, then 5,7,9 on consecutive cycles; level returns 0.
//  3 Back-to-back: CMD_RD at 10,14,18 with DQ 0..11 in cycles 13..24 -> 12 words out in order 0..11, no gap, no ovf_err.
//  4 Stall/overflow: dout_ready=0, 5 bursts (20 words) -> level saturates 16, ovf_err=1, first 16 words retained.
//    Then dout_ready=1 and err_clr pulse -> words 0..15 drain in order, ovf_err=0.
//  5 Full with simultaneous pop: level=16, dout_ready=1 during a burst -> level stays 16, no drop, ovf_err stays 0.
//  6 Reset mid-burst: assert rst_n=0 during beat 2 -> outputs cleared. The next CMD_RD after release captures correctly, with no stale words.

Source files
------------

// File: rtl/sdram_rd_capture_pkg.sv
// Shared definitions for the SDRAM read-capture block.
//   - SDRAM command encodings {CS_N,RAS_N,CAS_N,WE_N}, common to the sequencers
//     and the init block.
//   - Default CAS latency / burst length; these must match the mode register.
//   - Capture FSM state type and a read-command decode helper.
package sdram_rd_capture_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int DATA_W_DEF    = 16;
  localparam int CAS_LAT_DEF   = 3;
  localparam int BURST_LEN_DEF = 4;
  localparam int FIFO_AW_DEF   = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } cap_state_t;

  function automatic logic is_rd(input logic [3:0] cmd);
    return (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/sdram_rd_capture_if.sv
// Bundle of the capture block's SDRAM-side and user-side signals.
//   rd_cmd      command driven to the SDRAM pins by the read sequencer
//   sdram_dq    SDRAM data bus, read direction
//   dout        FIFO head word; dout_valid / dout_ready stream handshake
//   fifo_level  words currently buffered
//   ovf_err     sticky error flag, err_clr clears it
//   word_cnt    count of words written to the FIFO (only when
//               RDCAP_WORD_CNT_EN is defined)
// Modports: slave = capture block, master = sequencer/consumer side.
interface sdram_rd_capture_if #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 4
);

  logic [3:0]         rd_cmd;
  logic [DATA_W-1:0]  sdram_dq;
  logic [DATA_W-1:0]  dout;
  logic               dout_valid;
  logic               dout_ready;
  logic [FIFO_AW:0]   fifo_level;
  logic               ovf_err;
  logic               err_clr;
`ifdef RDCAP_WORD_CNT_EN
  logic [31:0]        word_cnt;

  modport slave (
    input  rd_cmd, sdram_dq, dout_ready, err_clr,
    output dout, dout_valid, fifo_level, ovf_err, word_cnt
  );

  modport master (
    output rd_cmd, sdram_dq, dout_ready, err_clr,
    input  dout, dout_valid, fifo_level, ovf_err, word_cnt
  );
`else
  modport slave (
    input  rd_cmd, sdram_dq, dout_ready, err_clr,
    output dout, dout_valid, fifo_level, ovf_err
  );

  modport master (
    output rd_cmd, sdram_dq, dout_ready, err_clr,
    input  dout, dout_valid, fifo_level, ovf_err
  );
`endif

endinterface

// File: rtl/rdcap_sync_fifo.sv
// First-word-fall-through synchronous FIFO for captured read words.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push/wdata  write request; dropped when full and no pop this cycle
//   pop         read request; ignored when empty
//   rdata       head word (0 when empty)
//   empty       no words buffered
//   level       registered word count, 0..2**FIFO_AW
//   drop        a push was rejected this cycle
module rdcap_sync_fifo #(
  parameter int DATA_W  = 16,
  parameter int FIFO_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic [FIFO_AW:0]  level,
  output logic              drop
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [FIFO_AW:0]  wr_ptr;
  logic [FIFO_AW:0]  rd_ptr;
  logic [FIFO_AW:0]  level_q;
  logic              full;
  logic              pop_en;
  logic              wr_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop_en = pop && !empty;
  // A pop on the same edge frees the slot, so push at full is still accepted.
  assign wr_en  = push && (!full || pop_en);
  assign drop   = push && full && !pop_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr[FIFO_AW-1:0]];
  assign level = level_q;

endmodule

// File: rtl/sdram_rd_capture.sv
// SDRAM read-data capture.
// Watches the command driven to the SDRAM pins; every CMD_RD starts a
// BURST_LEN-word capture CAS_LAT cycles later. Words are registered off DQ,
// buffered in an FWFT FIFO and streamed out on dout/dout_valid/dout_ready.
// Latency from CMD_RD to the first word on dout (empty FIFO) is CAS_LAT+2.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         sdram_rd_capture_if.slave (rd_cmd, sdram_dq, dout stream,
//               fifo_level, ovf_err, err_clr[, word_cnt])
// Optional build macro RDCAP_WORD_CNT_EN: adds bus.word_cnt, a 32-bit count
// of words written to the FIFO, cleared by reset and err_clr.
//
// Capture FSM
//   state   | meaning
//   S_IDLE  | no burst in progress, waiting for the delay-line output
//   S_BURST | pushing dq_q into the FIFO each cycle, beat_cnt = beat index
module sdram_rd_capture
  import sdram_rd_capture_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CAS_LAT   = CAS_LAT_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int FIFO_AW   = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  sdram_rd_capture_if.slave  bus
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_LEN - 1);

  logic                rd_start;
  logic [CAS_LAT-1:0]  dly;
  logic                dly_out;
  logic [DATA_W-1:0]   dq_q;
  cap_state_t          state;
  logic [BCW-1:0]      beat_cnt;
  logic                cap_push;
  logic                rd_overlap;
  logic                fifo_drop;
  logic                fifo_empty;
  logic                ovf_q;

  assign rd_start = is_rd(bus.rd_cmd);
  assign dly_out  = dly[CAS_LAT-1];

  // dly_out is high in the cycle DQ word 0 sits on the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly  <= '0;
      dq_q <= '0;
    end else begin
      dly  <= {dly[CAS_LAT-2:0], rd_start};
      dq_q <= bus.sdram_dq;
    end
  end

  // The FSM runs one cycle behind the pins, in step with dq_q, so beat n of
  // S_BURST pushes the word that was on DQ in the previous cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dly_out) begin
            state    <= S_BURST;
            beat_cnt <= '0;
          end
        end
        S_BURST: begin
          if (beat_cnt == BEAT_LAST) begin
            if (dly_out) beat_cnt <= '0;
            else         state    <= S_IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  assign cap_push = (state == S_BURST);
  // A new burst landing on a non-final beat would interrupt the current one;
  // it is not started and is reported through ovf_err.
  assign rd_overlap = dly_out && (state == S_BURST) && (beat_cnt != BEAT_LAST);

  rdcap_sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cap_push),
    .wdata (dq_q),
    .pop   (bus.dout_ready),
    .rdata (bus.dout),
    .empty (fifo_empty),
    .level (bus.fifo_level),
    .drop  (fifo_drop)
  );

  // A new error event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= fifo_drop | rd_overlap | (ovf_q & ~bus.err_clr);
  end

  assign bus.dout_valid = !fifo_empty;
  assign bus.ovf_err    = ovf_q;

`ifdef RDCAP_WORD_CNT_EN
  logic [31:0] word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       word_cnt_q <= '0;
    else if (bus.err_clr)             word_cnt_q <= '0;
    else if (cap_push && !fifo_drop)  word_cnt_q <= word_cnt_q + 32'd1;
  end

  assign bus.word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_sdram_rd_capture.sv
module tb_sdram_rd_capture;
  import sdram_rd_capture_pkg::*;

  localparam int CAS   = 3;
  localparam int BL    = 4;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_rd_capture_if #(.DATA_W(DW), .FIFO_AW(AW)) bus ();

  sdram_rd_capture #(
    .DATA_W(DW), .CAS_LAT(CAS), .BURST_LEN(BL), .FIFO_AW(AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: window-based capture schedule + word queue
  logic [15:0] m_q[$];
  bit          m_err;
  bit          start_at[int];
  int          cur_first, cur_last;
  bit          cap_prev;
  logic [15:0] dq_prev;
  int          cyc = 0;

  logic [15:0] got[$];
  logic        s_valid, s_ovf;
  logic [15:0] s_dout;
  logic [4:0]  s_level;

  typedef struct {
    logic [3:0]  cmd;
    logic [15:0] dq;
    bit          rdy;
    bit          exp_valid;
    logic [15:0] exp_dout;
    int          exp_level;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_err     = 1'b0;
    start_at.delete();
    cur_first = -100;
    cur_last  = -100;
    cap_prev  = 1'b0;
    dq_prev   = '0;
  endtask

  task automatic model_check();
    chk("dout_valid", bus.dout_valid, (m_q.size() > 0));
    if (m_q.size() > 0) chk("dout", bus.dout, m_q[0]);
    chk("fifo_level", bus.fifo_level, m_q.size());
    chk("ovf_err", bus.ovf_err, m_err);
  endtask

  // Advance the model across one clock edge using this cycle's inputs.
  task automatic model_step(input logic [3:0] cmd, input logic [15:0] dq,
                            input bit rdy, input bit clr);
    bit          set_err;
    bit          pop;
    bit          push;
    logic [15:0] pw;
    set_err = 1'b0;
    if (cmd == CMD_RD) start_at[cyc + CAS] = 1'b1;
    // word 0 of a read is on the pins at cyc; a start inside a running
    // burst window is refused and flagged
    if (start_at.exists(cyc)) begin
      if (cyc <= cur_last) set_err = 1'b1;
      else begin
        cur_first = cyc;
        cur_last  = cyc + BL - 1;
      end
      start_at.delete(cyc);
    end
    // a word on the pins in cycle C enters the FIFO at the end of C+1
    push     = cap_prev;
    pw       = dq_prev;
    cap_prev = (cyc >= cur_first) && (cyc <= cur_last);
    dq_prev  = dq;
    pop = rdy && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(pw);
      else set_err = 1'b1;
    end
    m_err = set_err | (m_err & !clr);
    cyc++;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic tick(input logic [3:0] cmd, input logic [15:0] dq,
                      input bit rdy, input bit clr);
    bus.rd_cmd     = cmd;
    bus.sdram_dq   = dq;
    bus.dout_ready = rdy;
    bus.err_clr    = clr;
    @(negedge clk);
    s_valid = bus.dout_valid;
    s_dout  = bus.dout;
    s_level = bus.fifo_level;
    s_ovf   = bus.ovf_err;
    model_check();
    if (rdy && bus.dout_valid) got.push_back(bus.dout);
    model_step(cmd, dq, rdy, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(CMD_NOP, 16'h0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] others[5];
    others = '{CMD_NOP, CMD_ACT, CMD_PRE, CMD_AREF, 4'b1111};

    // ---------- 1: reset held with activity on the inputs ----------
    rst_n          = 1'b0;
    bus.rd_cmd     = CMD_RD;
    bus.sdram_dq   = '0;
    bus.dout_ready = 1'b1;
    bus.err_clr    = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      bus.sdram_dq = 16'($urandom);
      bus.rd_cmd   = CMD_RD;
      @(negedge clk);
      chk("rst_valid", bus.dout_valid, 1'b0);
      chk("rst_level", bus.fifo_level, 5'd0);
      chk("rst_ovf", bus.ovf_err, 1'b0);
      chk("rst_dout", bus.dout, 16'h0);
      @(posedge clk);
      #1;
    end
    bus.rd_cmd = CMD_NOP;
    rst_n      = 1'b1;
    drain(3);

    // ---------- 2: single read, table-driven ----------
    for (int c = 0; c < 21; c++) begin
      tbl[c].cmd       = (c == 10) ? CMD_RD : CMD_NOP;
      tbl[c].dq        = (c >= 13 && c <= 16) ? 16'(3 + 2 * (c - 13)) : 16'hBEEF;
      tbl[c].rdy       = 1'b1;
      tbl[c].exp_valid = (c >= 15 && c <= 18);
      tbl[c].exp_dout  = (c >= 15 && c <= 18) ? 16'(3 + 2 * (c - 15)) : 16'h0;
      tbl[c].exp_level = (c >= 15 && c <= 18) ? 1 : 0;
    end
    for (int c = 0; c < 21; c++) begin
      tick(tbl[c].cmd, tbl[c].dq, tbl[c].rdy, 1'b0);
      chk($sformatf("t2_valid_c%0d", c), s_valid, tbl[c].exp_valid);
      if (tbl[c].exp_valid) chk($sformatf("t2_dout_c%0d", c), s_dout, tbl[c].exp_dout);
      chk($sformatf("t2_level_c%0d", c), s_level, tbl[c].exp_level);
    end

    // ---------- 3: back-to-back bursts ----------
    got.delete();
    for (int c = 0; c < 31; c++) begin
      tick((c == 10 || c == 14 || c == 18) ? CMD_RD : CMD_NOP,
           (c >= 13 && c <= 24) ? 16'(c - 13) : (16'hF000 | 16'(c)), 1'b1, 1'b0);
      if (c >= 15 && c <= 26) chk($sformatf("t3_nogap_c%0d", c), s_valid, 1'b1);
    end
    chk("t3_count", got.size(), 12);
    for (int i = 0; i < got.size() && i < 12; i++) chk($sformatf("t3_word%0d", i), got[i], i);
    chk("t3_ovf", s_ovf, 1'b0);

    // ---------- 4: stall until overflow, then clear and drain ----------
    got.delete();
    for (int c = 0; c < 40; c++) begin
      tick((c >= 10 && c <= 26 && (c - 10) % 4 == 0) ? CMD_RD : CMD_NOP,
           (c >= 13 && c <= 32) ? 16'(c - 13) : (16'hE000 | 16'(c)), 1'b0, 1'b0);
    end
    chk("t4_level_full", s_level, 5'd16);
    chk("t4_ovf_set", s_ovf, 1'b1);
    for (int c = 0; c < 20; c++) tick(CMD_NOP, 16'h0, 1'b1, (c == 0));
    chk("t4_count", got.size(), 16);
    for (int i = 0; i < got.size() && i < 16; i++) chk($sformatf("t4_word%0d", i), got[i], i);
    chk("t4_ovf_clr", s_ovf, 1'b0);
    chk("t4_level_empty", s_level, 5'd0);

    // ---------- 5: full FIFO with simultaneous push and pop ----------
    got.delete();
    for (int c = 0; c < 46; c++) begin
      logic [15:0] dq;
      dq = (c >= 13 && c <= 28) ? 16'(c - 13) :
           (c >= 35 && c <= 38) ? 16'(16 + c - 35) : (16'hD000 | 16'(c));
      tick(((c >= 10 && c <= 22 && (c - 10) % 4 == 0) || c == 32) ? CMD_RD : CMD_NOP,
           dq, (c >= 36 && c <= 39), 1'b0);
      if (c >= 36 && c <= 40) chk($sformatf("t5_level_c%0d", c), s_level, 5'd16);
    end
    chk("t5_ovf", s_ovf, 1'b0);
    drain(20);
    chk("t5_count", got.size(), 20);
    for (int i = 0; i < got.size() && i < 20; i++) chk($sformatf("t5_word%0d", i), got[i], i);

    // ---------- 6: asynchronous reset during beat 2 ----------
    got.delete();
    for (int c = 0; c < 6; c++)
      tick((c == 0) ? CMD_RD : CMD_NOP, (c >= 3) ? (16'h5500 | 16'(c)) : 16'h0, 1'b0, 1'b0);
    bus.rd_cmd   = CMD_NOP;
    bus.sdram_dq = 16'h5506;
    @(negedge clk);
    chk("t6_pre_level", bus.fifo_level, 5'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.dout_valid, 1'b0);
    chk("t6_rst_level", bus.fifo_level, 5'd0);
    chk("t6_rst_ovf", bus.ovf_err, 1'b0);
    chk("t6_rst_dout", bus.dout, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 15; c++)
      tick((c == 2) ? CMD_RD : CMD_NOP,
           (c >= 5 && c <= 8) ? (16'h6600 | 16'(c - 5)) : 16'h5555, 1'b1, 1'b0);
    chk("t6_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk($sformatf("t6_word%0d", i), got[i], 16'h6600 | 16'(i));

    // ---------- random traffic against the model ----------
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] cmd;
      bit         rdy;
      if (((i / 150) % 2) == 0) rdy = ($urandom_range(0, 9) < 9);
      else                      rdy = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 11) < 2) cmd = CMD_RD;
      else                           cmd = others[$urandom_range(0, 4)];
      tick(cmd, 16'($urandom), rdy, ($urandom_range(0, 31) == 0));
    end
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
